// File: rtl/stopwatch_key_ctrl_pkg.sv
// Shared types and constants for the stopwatch key control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } state_t;

  localparam int KEY_SS  = 0;
  localparam int KEY_LAP = 1;
  localparam int KEY_CLR = 2;
  localparam int NUM_KEYS = 3;

endpackage

// File: rtl/stopwatch_key_ctrl_if.sv
// Key inputs and control outputs between the stopwatch key stage and its surroundings.
interface stopwatch_key_ctrl_if;
  import stopwatch_pkg::*;

  // No valid/ready pairs: key_n is a raw level, run and lap_hold are levels,
  // and clear_pulse is a single-cycle strobe that is never back-pressured.
  logic [NUM_KEYS-1:0] key_n;
  logic                run;
  logic                lap_hold;
  logic                clear_pulse;
  state_t              state;

  modport master (
    output key_n,
    input  run,
    input  lap_hold,
    input  clear_pulse,
    input  state
  );

  modport slave (
    input  key_n,
    output run,
    output lap_hold,
    output clear_pulse,
    output state
  );
endinterface

// File: rtl/stopwatch_key_ctrl_debounce.sv
// One pushbutton: 2-flop synchroniser, saturating debounce counter, press strobe.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
      // Falling edge of the debounced level only; release gives no event.
      press    <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key control: debounced keys drive a run/pause/lap FSM with registered outputs.
module stopwatch_key_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stopwatch_key_ctrl_if.slave  sw
);

  logic [NUM_KEYS-1:0] press;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n   (sw.key_n[i]),
      .press   (press[i])
    );
  end

  state_t state_q, state_d;
  logic   run_q, run_d;
  logic   lap_q, lap_d;
  logic   clr_q, clr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      lap_q   <= lap_d;
      clr_q   <= clr_d;
    end
  end

  // One winner per cycle (clr > ss > lap); a winner that the current state
  // ignores still suppresses the lower-priority presses.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (press[KEY_CLR]) begin
      if (state_q == IDLE || state_q == PAUSED) begin
        state_d = IDLE;
        clr_d   = 1'b1;
      end
    end else if (press[KEY_SS]) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        LAP:     state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end else if (press[KEY_LAP]) begin
      case (state_q)
        RUNNING: state_d = LAP;
        LAP:     state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end
    run_d = (state_d == RUNNING) || (state_d == LAP);
    lap_d = (state_d == LAP);
  end

  assign sw.state       = state_q;
  assign sw.run         = run_q;
  assign sw.lap_hold    = lap_q;
  assign sw.clear_pulse = clr_q;

endmodule
